sr_target_loader: RTL and testbench
===================================

# sr_target_loader

Serial transmitter that loads a 32-bit divider target into a divider block's internal shift register. It drives the divider's `sr_data`, `sr_data_clock`, `sr_div_data_enable` and `sr_div_data_reset` inputs from a parallel word. All outputs are generated synchronously from a single system clock. It sits between host/control logic and one or more divider instances, and it is the only writer of their target registers.

## Interface
- `HALF_PERIOD`, default 4: system cycles per half-period of `sr_data_clock`; legal range 1 to 255.
- `CLEAR_BEFORE_LOAD`, default 1: 1 inserts a `sr_div_data_reset` pulse before shifting; 0 omits it.
- `sys_clock` input 1: system clock; all logic on the rising edge.
- `external_reset` input 1: asynchronous, active-high reset.
- `load_value` input 32: target word; sampled only on the accepted start cycle.
- `load_start` input 1: start request; single-cycle or level.
- `load_abort` input 1: synchronous abort of an active transfer.
- `busy` output 1: transfer in progress.
- `done` output 1: one-cycle pulse at successful completion.
- `sr_data` output 1: serial data, MSB first.
- `sr_data_clock` output 1: serial shift clock; the receiver samples on its rising edge.
- `sr_div_data_enable` output 1: high for the whole shift window; the receiver's outputs are blocked while it is high.
- `sr_div_data_reset` output 1: receiver shift-register clear.

## Operation
- **States:** IDLE, CLEAR, SHIFT_LO, SHIFT_HI, TAIL, DONE. All outputs are registered.
- **IDLE:** all outputs 0. `load_start`=1 latches `load_value` into a 32-bit shadow register.
  - Next state is CLEAR when `CLEAR_BEFORE_LOAD`=1, otherwise SHIFT_LO.
  - The bit index is set to 31.
- **CLEAR:** `sr_div_data_reset`=1, `sr_div_data_enable`=0, `sr_data_clock`=0 for `HALF_PERIOD` cycles, then go to SHIFT_LO.
- **SHIFT_LO:** `sr_div_data_enable`=1, `sr_data_clock`=0, `sr_data`=shadow[index]. Lasts `HALF_PERIOD` cycles, then go to SHIFT_HI.
- **SHIFT_HI:** `sr_data_clock`=1 and `sr_data` unchanged for `HALF_PERIOD` cycles.
  - If index is 0, go to TAIL.
  - Otherwise decrement index and go to SHIFT_LO.
  - `sr_data` changes only on entry to SHIFT_LO, so it is stable at least `HALF_PERIOD` cycles either side of each rising edge.
- **TAIL:** `sr_data_clock`=0, `sr_div_data_enable`=1, `sr_data`=0 for `HALF_PERIOD` cycles, then go to DONE.
- **DONE:** held for one cycle.
  - `done`=1, `busy`=0, `sr_div_data_enable`=0.
  - `load_start` in this cycle is accepted exactly as in IDLE.
  - With no start, return to IDLE.
- **busy:** 1 in CLEAR, SHIFT_LO, SHIFT_HI and TAIL; 0 in IDLE and DONE.
- **load_start while busy:** ignored; the shadow register is not reloaded.
- **load_abort while busy:** next state is IDLE; all outputs 0 next cycle; `done` is not pulsed. Ignored when not busy. Abort takes priority over every other transition.
- **Half-period counter:** 8 bits, counts 0 to `HALF_PERIOD`-1 and wraps on each state change. There is no off-by-one tolerance.

## Timing
- **Reset:** all outputs 0 immediately and asynchronously. State is IDLE, counter 0, shadow register 0.
  - Reset during a transfer leaves the receiver partially loaded.
  - Recovery is a new load with `CLEAR_BEFORE_LOAD`=1.
- **Start-to-busy:** start is sampled on edge E; `busy` rises after E (1-cycle latency).
- **Busy duration:** exactly (`CLEAR_BEFORE_LOAD` + 65) × `HALF_PERIOD` cycles. `done` is high for the single cycle that follows.
  - `HALF_PERIOD`=4, clear on: 264 busy cycles, `done` in cycle 265 after E.
- **Rising edges:** exactly 32 rising `sr_data_clock` edges per completed transfer; 0 to 31 on abort.
- **Enable window:** `sr_div_data_enable` rises with the first SHIFT_LO cycle and falls on entry to DONE.
  - It is never high in the same cycle as `sr_div_data_reset`.
- **Back-to-back:** a start in the DONE cycle gives `busy` high again on the next cycle, with no idle gap.

## Test plan
- `HALF_PERIOD`=4, clear on, load 32'h0000_0003 → one 4-cycle reset pulse; 32 rising edges; behavioural sr32 model captures 32'h0000_0003; 264 busy cycles; one `done`.
- `HALF_PERIOD`=1, clear off, load 32'hA5A5_A5A5, then start in the DONE cycle with 32'hFFFF_FFFF → 65 busy cycles each, no idle gap; model reads A5A5A5A5 then FFFFFFFF.
- `load_start` with 32'h1234_5678 in cycle 10 of a transfer of 32'h0000_00FF → ignored; model ends at 32'h0000_00FF.
- `load_abort` after the 12th rising edge → all outputs 0 next cycle; no `done`; exactly 12 edges counted.
- Assert `external_reset` mid-SHIFT_HI → outputs 0 before the next clock edge. A subsequent clear-on load of 32'hDEAD_BEEF reads back correctly.
- Checker over all scenarios: `sr_data` stable while `sr_data_clock` is high; enable and reset never high together.

Source files
------------

// File: rtl/sr_target_loader.sv
// Serial loader for a divider's 32-bit target shift register: optional clear pulse,
// then 32 MSB-first bits on a slow shift clock, then a quiet tail before signalling done.
module sr_target_loader #(
    parameter int HALF_PERIOD       = 4,
    parameter int CLEAR_BEFORE_LOAD = 1
) (
    input  logic        sys_clock,
    input  logic        external_reset,
    input  logic [31:0] load_value,
    input  logic        load_start,
    input  logic        load_abort,
    output logic        busy,
    output logic        done,
    output logic        sr_data,
    output logic        sr_data_clock,
    output logic        sr_div_data_enable,
    output logic        sr_div_data_reset
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        TAIL     = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] shadow_q, shadow_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        data_q, data_d;
    logic        sck_q, sck_d;
    logic        en_q, en_d;
    logic        clr_q, clr_d;
    logic        last;
    logic        active;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 8'd1;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        last     = (cnt_q == HP_LAST);
        active   = (state_q == CLEAR) || (state_q == SHIFT_LO) ||
                   (state_q == SHIFT_HI) || (state_q == TAIL);

        case (state_q)
            IDLE, DONE: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
                if (load_start) begin
                    shadow_d = load_value;
                    idx_d    = 5'd31;
                    state_d  = (CLEAR_BEFORE_LOAD != 0) ? CLEAR : SHIFT_LO;
                end
            end
            CLEAR: if (last) begin
                state_d = SHIFT_LO;
                cnt_d   = 8'd0;
            end
            SHIFT_LO: if (last) begin
                state_d = SHIFT_HI;
                cnt_d   = 8'd0;
            end
            SHIFT_HI: if (last) begin
                cnt_d = 8'd0;
                if (idx_q == 5'd0) begin
                    state_d = TAIL;
                end else begin
                    idx_d   = idx_q - 5'd1;
                    state_d = SHIFT_LO;
                end
            end
            TAIL: if (last) begin
                state_d = DONE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        if (active && load_abort) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end

        // Outputs are decoded from the next state so they register alongside it.
        busy_d = (state_d == CLEAR) || (state_d == SHIFT_LO) ||
                 (state_d == SHIFT_HI) || (state_d == TAIL);
        done_d = (state_d == DONE);
        clr_d  = (state_d == CLEAR);
        sck_d  = (state_d == SHIFT_HI);
        en_d   = (state_d == SHIFT_LO) || (state_d == SHIFT_HI) || (state_d == TAIL);
        data_d = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? shadow_d[idx_d] : 1'b0;
    end

    always_ff @(posedge sys_clock or posedge external_reset) begin
        if (external_reset) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            idx_q    <= 5'd0;
            shadow_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= 1'b0;
            sck_q    <= 1'b0;
            en_q     <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            data_q   <= data_d;
            sck_q    <= sck_d;
            en_q     <= en_d;
            clr_q    <= clr_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign sr_data            = data_q;
    assign sr_data_clock      = sck_q;
    assign sr_div_data_enable = en_q;
    assign sr_div_data_reset  = clr_q;

endmodule

// File: tb/tb_sr_target_loader.sv
// Bench for sr_target_loader: two instances (HALF_PERIOD=4 with clear, HALF_PERIOD=1 without)
// feeding a behavioural 32-bit receiver model each.
module tb_sr_target_loader;

    logic        clk;
    logic [1:0]  rst;
    logic [31:0] lv [2];
    logic [1:0]  start, abort;
    logic [1:0]  busy, done, sd, sck, en, srr;

    sr_target_loader #(.HALF_PERIOD(4), .CLEAR_BEFORE_LOAD(1)) u_a (
        .sys_clock(clk), .external_reset(rst[0]), .load_value(lv[0]),
        .load_start(start[0]), .load_abort(abort[0]), .busy(busy[0]), .done(done[0]),
        .sr_data(sd[0]), .sr_data_clock(sck[0]), .sr_div_data_enable(en[0]),
        .sr_div_data_reset(srr[0]));

    sr_target_loader #(.HALF_PERIOD(1), .CLEAR_BEFORE_LOAD(0)) u_b (
        .sys_clock(clk), .external_reset(rst[1]), .load_value(lv[1]),
        .load_start(start[1]), .load_abort(abort[1]), .busy(busy[1]), .done(done[1]),
        .sr_data(sd[1]), .sr_data_clock(sck[1]), .sr_div_data_enable(en[1]),
        .sr_div_data_reset(srr[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Receiver model and event counters, sampled on the falling edge.
    int          cyc = 0;
    int          viol = 0;
    int          edges [2] = '{0, 0};
    int          busy_tot [2] = '{0, 0};
    int          done_tot [2] = '{0, 0};
    int          rst_tot [2] = '{0, 0};
    int          done_cyc [2] = '{0, 0};
    logic [31:0] model [2] = '{32'd0, 32'd0};
    logic [31:0] model_done [2] = '{32'd0, 32'd0};
    logic [1:0]  prev_sck = 2'b00;
    logic [1:0]  prev_sd = 2'b00;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        viol <= viol + int'((sck[0] && prev_sck[0] && sd[0] != prev_sd[0]) || (en[0] && srr[0]))
                     + int'((sck[1] && prev_sck[1] && sd[1] != prev_sd[1]) || (en[1] && srr[1]));
        for (int i = 0; i < 2; i++) begin
            if (srr[i]) begin
                model[i] <= 32'd0;
                rst_tot[i] <= rst_tot[i] + 1;
            end else if (sck[i] && !prev_sck[i]) begin
                model[i] <= {model[i][30:0], sd[i]};
                edges[i] <= edges[i] + 1;
            end
            if (busy[i]) busy_tot[i] <= busy_tot[i] + 1;
            if (done[i]) begin
                done_tot[i] <= done_tot[i] + 1;
                done_cyc[i] <= cyc + 1;
                model_done[i] <= model[i];
            end
        end
        prev_sck <= sck;
        prev_sd  <= sd;
    end

    function automatic logic [5:0] outs(input int i);
        return {busy[i], done[i], sd[i], sck[i], en[i], srr[i]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int i);
        for (int k = 0; k < 3000 && !done[i]; k++) tick();
        chk("done_seen", {31'd0, done[i]}, 32'd1);
    endtask

    typedef struct {
        int          inst;
        logic [31:0] val;
        int          exp_busy;
        int          exp_done_at;
        int          exp_rst;
        logic [31:0] exp_model;
    } vec_t;

    vec_t vecs [5];
    int b0, e0, r0, d0, ce, c1;

    task automatic launch(input int i, input logic [31:0] v);
        tick();
        b0 = busy_tot[i]; e0 = edges[i]; r0 = rst_tot[i]; d0 = done_tot[i];
        lv[i] = v;
        start[i] = 1'b1;
        tick();
        ce = cyc;
        start[i] = 1'b0;
        lv[i] = 32'd0;
    endtask

    initial begin
        rst = 2'b11; start = 2'b00; abort = 2'b00;
        lv[0] = 32'd0; lv[1] = 32'd0;
        vecs[0] = '{0, 32'hDEAD_BEEF, 264, 265, 4, 32'hDEAD_BEEF};
        vecs[1] = '{0, 32'h0000_0003, 264, 265, 4, 32'h0000_0003};
        vecs[2] = '{0, 32'h8000_0001, 264, 265, 4, 32'h8000_0001};
        vecs[3] = '{1, 32'h0000_0005, 65, 66, 0, 32'h0000_0005};
        vecs[4] = '{1, 32'h7FFF_FFFE, 65, 66, 0, 32'h7FFF_FFFE};

        repeat (3) tick();
        chk("reset_outs_a", {26'd0, outs(0)}, 32'd0);
        chk("reset_outs_b", {26'd0, outs(1)}, 32'd0);
        rst = 2'b00;

        // Reset asserted mid shift-high phase must clear outputs before the next edge.
        launch(0, 32'h0F0F_0F0F);
        for (int k = 0; k < 3000 && !sck[0]; k++) tick();
        #1 rst[0] = 1'b1;
        #1 chk("async_reset_outs", {26'd0, outs(0)}, 32'd0);
        tick(); tick();
        rst[0] = 1'b0;
        chk("post_reset_idle", {26'd0, outs(0)}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            launch(vecs[v].inst, vecs[v].val);
            chk("busy_after_start", {31'd0, busy[vecs[v].inst]}, 32'd1);
            wait_done(vecs[v].inst);
            tick();
            chk("busy_cycles", busy_tot[vecs[v].inst] - b0, vecs[v].exp_busy);
            chk("done_cycle", done_cyc[vecs[v].inst] - ce, vecs[v].exp_done_at);
            chk("done_count", done_tot[vecs[v].inst] - d0, 1);
            chk("rising_edges", edges[vecs[v].inst] - e0, 32);
            chk("clear_cycles", rst_tot[vecs[v].inst] - r0, vecs[v].exp_rst);
            chk("model_value", model_done[vecs[v].inst], vecs[v].exp_model);
            chk("idle_after_done", {26'd0, outs(vecs[v].inst)}, 32'd0);
        end

        // Back-to-back: second start lands in the DONE cycle.
        launch(1, 32'hA5A5_A5A5);
        wait_done(1);
        lv[1] = 32'hFFFF_FFFF;
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        lv[1] = 32'd0;
        c1 = done_cyc[1];
        chk("b2b_first_done_at", c1 - ce, 66);
        chk("b2b_first_model", model_done[1], 32'hA5A5_A5A5);
        chk("b2b_no_gap_busy", {31'd0, busy[1]}, 32'd1);
        wait_done(1);
        tick();
        chk("b2b_second_done_at", done_cyc[1] - c1, 66);
        chk("b2b_second_model", model_done[1], 32'hFFFF_FFFF);
        chk("b2b_busy_cycles", busy_tot[1] - b0, 130);
        chk("b2b_done_count", done_tot[1] - d0, 2);

        // Start while busy must not reload the shadow word.
        launch(0, 32'h0000_00FF);
        repeat (9) tick();
        lv[0] = 32'h1234_5678;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        lv[0] = 32'd0;
        wait_done(0);
        tick();
        chk("ignored_start_model", model_done[0], 32'h0000_00FF);
        chk("ignored_start_busy", busy_tot[0] - b0, 264);
        chk("ignored_start_done", done_tot[0] - d0, 1);

        // Abort after the 12th rising edge.
        launch(0, 32'hFFFF_FFFF);
        for (int k = 0; k < 3000 && (edges[0] - e0) < 12; k++) tick();
        abort[0] = 1'b1;
        tick();
        chk("abort_outs", {26'd0, outs(0)}, 32'd0);
        abort[0] = 1'b0;
        repeat (300) tick();
        chk("abort_edges", edges[0] - e0, 12);
        chk("abort_no_done", done_tot[0] - d0, 0);
        chk("abort_stays_idle", {31'd0, busy[0]}, 32'd0);

        chk("protocol_violations", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
